// File: rtl/lat_tester_pkg.sv
// Shared definitions for the latency tester: FSM encoding, box position codes,
// box geometry divisors and default limits.
package lat_tester_pkg;

  localparam int unsigned LT_CNT_W = 24;

  // 0.5 s at 27 MHz
  localparam logic [23:0] LT_TIMEOUT_DEFAULT  = 24'd13500000;
  localparam logic [7:0]  LT_DEBOUNCE_DEFAULT = 8'd16;

  localparam logic [1:0] LT_POS_CENTER = 2'd0;
  localparam logic [1:0] LT_POS_LEFT   = 2'd1;
  localparam logic [1:0] LT_POS_RIGHT  = 2'd2;
  localparam logic [1:0] LT_POS_TOP    = 2'd3;

  // Box size as a fraction of the active picture
  localparam int unsigned LT_WIDTH_DIV  = 4;
  localparam int unsigned LT_HEIGHT_DIV = 4;

  typedef enum logic [2:0] {
    LT_IDLE       = 3'd0,
    LT_WAIT_FRAME = 3'd1,
    LT_MEASURE    = 3'd2,
    LT_RELEASE    = 3'd3,
    LT_DONE       = 3'd4
  } lt_state_e;

endpackage

// File: rtl/lt_sensor_filter.sv
// Photodiode input conditioning: two-flop synchroniser, inversion to active-high,
// optional debounce selected by LT_SENSOR_DEBOUNCE_EN.
module lt_sensor_filter
  import lat_tester_pkg::*;
#(
  parameter logic [7:0] DEBOUNCE_LEN = LT_DEBOUNCE_DEFAULT
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic i_sensor_n,
  output logic o_sensor_on
);

  logic r_sync1;
  logic r_sync2;

  // Inverting before the first flop keeps the reset value meaning "no light"
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~i_sensor_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LT_SENSOR_DEBOUNCE_EN
  localparam bit DEBOUNCE_ON = 1'b1;
`else
  localparam bit DEBOUNCE_ON = 1'b0;
`endif

  generate
    if (DEBOUNCE_ON && (DEBOUNCE_LEN != 8'd0)) begin : g_debounce
      logic [7:0] r_run;
      logic       r_filt;

      // Flip only after DEBOUNCE_LEN consecutive disagreeing samples
      always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
          r_run  <= 8'd0;
          r_filt <= 1'b0;
        end else if (r_sync2 == r_filt) begin
          r_run <= 8'd0;
        end else if (r_run == (DEBOUNCE_LEN - 8'd1)) begin
          r_run  <= 8'd0;
          r_filt <= r_sync2;
        end else begin
          r_run <= r_run + 8'd1;
        end
      end

      assign o_sensor_on = r_filt;
    end else begin : g_bypass
      assign o_sensor_on = r_sync2;
    end
  endgenerate

endmodule

// File: rtl/lat_tester_ctrl.sv
// Display latency tester controller: draws a box from a frame start and counts
// clk27 cycles until the photodiode sees it (lat) and releases (stb).
// Sensor debounce is enabled by defining LT_SENSOR_DEBOUNCE_EN.
module lat_tester_ctrl
  import lat_tester_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = LT_TIMEOUT_DEFAULT,
  parameter logic [7:0]  DEBOUNCE_LEN   = LT_DEBOUNCE_DEFAULT
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  mode_in,
  input  logic        VSYNC_in,
  input  logic        sensor_n,
  output logic        lt_active,
  output logic [1:0]  lt_mode,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        sensor_err,
  output logic [23:0] lat_result,
  output logic [23:0] stb_result
);

  logic                w_sensor_on;
  logic                w_frame_start;
  logic                w_cnt_at_limit;
  logic                r_vsync_d;
  logic [LT_CNT_W-1:0] r_cnt;
  lt_state_e           r_state;

  lt_sensor_filter #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_sensor_filter (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .i_sensor_n  (sensor_n),
    .o_sensor_on (w_sensor_on)
  );

  // VSYNC is negative polarity; its falling edge marks the frame start
  assign w_frame_start  = r_vsync_d & ~VSYNC_in;
  assign w_cnt_at_limit = (r_cnt == (TIMEOUT_CYCLES - 24'd1));

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LT_IDLE;
      r_vsync_d  <= 1'b0;
      r_cnt      <= '0;
      lt_active  <= 1'b0;
      lt_mode    <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      sensor_err <= 1'b0;
      lat_result <= '0;
      stb_result <= '0;
    end else begin
      r_vsync_d <= VSYNC_in;
      done      <= 1'b0;
      if (abort) begin
        r_state   <= LT_IDLE;
        lt_active <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          LT_IDLE: begin
            if (start) begin
              lt_mode    <= mode_in;
              timeout    <= 1'b0;
              sensor_err <= 1'b0;
              busy       <= 1'b1;
              r_state    <= LT_WAIT_FRAME;
            end
          end
          LT_WAIT_FRAME: begin
            if (w_frame_start) begin
              if (w_sensor_on) begin
                sensor_err <= 1'b1;
                done       <= 1'b1;
                r_state    <= LT_DONE;
              end else begin
                lt_active <= 1'b1;
                r_cnt     <= '0;
                r_state   <= LT_MEASURE;
              end
            end
          end
          // Sensor event takes priority over the timeout limit
          LT_MEASURE: begin
            r_cnt <= r_cnt + 24'd1;
            if (w_sensor_on) begin
              lat_result <= r_cnt;
              lt_active  <= 1'b0;
              r_cnt      <= '0;
              r_state    <= LT_RELEASE;
            end else if (w_cnt_at_limit) begin
              timeout   <= 1'b1;
              lt_active <= 1'b0;
              done      <= 1'b1;
              r_state   <= LT_DONE;
            end
          end
          LT_RELEASE: begin
            r_cnt <= r_cnt + 24'd1;
            if (!w_sensor_on) begin
              stb_result <= r_cnt;
              done       <= 1'b1;
              r_state    <= LT_DONE;
            end else if (w_cnt_at_limit) begin
              timeout <= 1'b1;
              done    <= 1'b1;
              r_state <= LT_DONE;
            end
          end
          LT_DONE: begin
            busy    <= 1'b0;
            r_state <= LT_IDLE;
          end
          default: begin
            lt_active <= 1'b0;
            busy      <= 1'b0;
            r_state   <= LT_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lat_tester_ctrl.sv
// Directed bench for lat_tester_ctrl; timeout shortened to 2000 cycles.
module tb_lat_tester_ctrl;

  localparam logic [23:0] TB_TIMEOUT = 24'd2000;
`ifdef LT_SENSOR_DEBOUNCE_EN
  localparam int unsigned EXTRA = 16;
`else
  localparam int unsigned EXTRA = 0;
`endif

  logic        clk27    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [1:0]  mode_in  = 2'd0;
  logic        VSYNC_in = 1'b1;
  logic        sensor_n = 1'b1;
  logic        lt_active;
  logic [1:0]  lt_mode;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        sensor_err;
  logic [23:0] lat_result;
  logic [23:0] stb_result;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  always #5 clk27 = ~clk27;

  always @(negedge clk27) if (done) n_done++;

  lat_tester_ctrl #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .DEBOUNCE_LEN   (8'd16)
  ) dut (
    .clk27      (clk27),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .mode_in    (mode_in),
    .VSYNC_in   (VSYNC_in),
    .sensor_n   (sensor_n),
    .lt_active  (lt_active),
    .lt_mode    (lt_mode),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .sensor_err (sensor_err),
    .lat_result (lat_result),
    .stb_result (stb_result)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk27);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m);
    start   = 1'b1;
    mode_in = m;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({lt_active, lt_mode, busy, done, timeout, sensor_err, lat_result, stb_result} !== 56'd0)
      $display("FAIL reset_outputs got act=%b mode=%b busy=%b done=%b to=%b err=%b lat=%0d stb=%0d exp all 0",
               lt_active, lt_mode, busy, done, timeout, sensor_err, lat_result, stb_result);
    else n_pass++;
    #6 reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_measure;
    do_start(2'b01);
    n_checks++;
    if ({busy, lt_mode, lt_active} !== 4'b1010)
      $display("FAIL start_accept got busy=%b mode=%b act=%b exp 1 01 0", busy, lt_mode, lt_active);
    else n_pass++;
    tick(5);
    VSYNC_in = 1'b0;
    n_checks++;
    if (lt_active !== 1'b0) $display("FAIL act_before_frame got %b exp 0", lt_active);
    else n_pass++;
    tick(1);
    n_checks++;
    if (lt_active !== 1'b1) $display("FAIL act_after_frame got %b exp 1", lt_active);
    else n_pass++;
    tick(4);
    VSYNC_in = 1'b1;
`ifdef LT_SENSOR_DEBOUNCE_EN
    tick(96);
    sensor_n = 1'b0;
    tick(10);
    sensor_n = 1'b1;
    tick(890);
`else
    tick(996);
`endif
    sensor_n = 1'b0;
    tick(2 + EXTRA);
    n_checks++;
    if ({lt_active, lat_result} !== {1'b1, 24'd0})
      $display("FAIL pre_detect got act=%b lat=%0d exp 1 0", lt_active, lat_result);
    else n_pass++;
    tick(1);
    n_checks++;
    if (lat_result !== 24'(1002 + EXTRA))
      $display("FAIL lat_result got %0d exp %0d", lat_result, 1002 + EXTRA);
    else n_pass++;
    n_checks++;
    if ({lt_active, busy, done} !== 3'b010)
      $display("FAIL detect_flags got act=%b busy=%b done=%b exp 0 1 0", lt_active, busy, done);
    else n_pass++;
    tick(499);
    sensor_n = 1'b1;
    tick(2 + EXTRA);
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_early got %b exp 0", done);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({done, stb_result} !== {1'b1, 24'(501 + EXTRA)})
      $display("FAIL stb_result got done=%b stb=%0d exp 1 %0d", done, stb_result, 501 + EXTRA);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({done, busy, lat_result} !== {2'b00, 24'(1002 + EXTRA)})
      $display("FAIL measure_end got done=%b busy=%b lat=%0d exp 0 0 %0d", done, busy, lat_result, 1002 + EXTRA);
    else n_pass++;
    n_checks++;
    if (n_done !== 1) $display("FAIL done_count_measure got %0d exp 1", n_done);
    else n_pass++;
  endtask

  task automatic test_sensor_err;
    sensor_n = 1'b0;
    tick(30);
    do_start(2'b10);
    tick(3);
    VSYNC_in = 1'b0;
    tick(1);
    VSYNC_in = 1'b1;
    n_checks++;
    if ({sensor_err, done, lt_active, busy} !== 4'b1101)
      $display("FAIL sensor_err got err=%b done=%b act=%b busy=%b exp 1 1 0 1", sensor_err, done, lt_active, busy);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({sensor_err, done, busy, lt_active} !== 4'b1000)
      $display("FAIL sensor_err_hold got err=%b done=%b busy=%b act=%b exp 1 0 0 0", sensor_err, done, busy, lt_active);
    else n_pass++;
    n_checks++;
    if (n_done !== 2) $display("FAIL done_count_err got %0d exp 2", n_done);
    else n_pass++;
    sensor_n = 1'b1;
    tick(30);
  endtask

  task automatic test_timeout;
    do_start(2'b11);
    n_checks++;
    if ({sensor_err, lt_mode} !== 3'b011)
      $display("FAIL start_clears_err got err=%b mode=%b exp 0 11", sensor_err, lt_mode);
    else n_pass++;
    tick(2);
    VSYNC_in = 1'b0;
    tick(1);
    VSYNC_in = 1'b1;
    tick(1999);
    n_checks++;
    if ({lt_active, timeout, done} !== 3'b100)
      $display("FAIL at_limit got act=%b to=%b done=%b exp 1 0 0", lt_active, timeout, done);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({timeout, lt_active, done, lat_result} !== {3'b101, 24'(1002 + EXTRA)})
      $display("FAIL timeout got to=%b act=%b done=%b lat=%0d exp 1 0 1 %0d", timeout, lt_active, done, lat_result, 1002 + EXTRA);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({timeout, done, busy} !== 3'b100)
      $display("FAIL timeout_hold got to=%b done=%b busy=%b exp 1 0 0", timeout, done, busy);
    else n_pass++;
    n_checks++;
    if (n_done !== 3) $display("FAIL done_count_timeout got %0d exp 3", n_done);
    else n_pass++;
  endtask

  task automatic test_abort;
    do_start(2'b01);
    tick(2);
    VSYNC_in = 1'b0;
    tick(1);
    VSYNC_in = 1'b1;
    start   = 1'b1;
    mode_in = 2'b10;
    tick(1);
    start   = 1'b0;
    n_checks++;
    if ({lt_active, busy, lt_mode} !== 4'b1101)
      $display("FAIL start_ignored got act=%b busy=%b mode=%b exp 1 1 01", lt_active, busy, lt_mode);
    else n_pass++;
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    n_checks++;
    if ({lt_active, busy, done} !== 3'b000)
      $display("FAIL abort got act=%b busy=%b done=%b exp 0 0 0", lt_active, busy, done);
    else n_pass++;
    tick(20);
    n_checks++;
    if (n_done !== 3) $display("FAIL abort_no_done got %0d exp 3", n_done);
    else n_pass++;
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_over_start got busy=%b exp 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_start(2'b10);
    tick(2);
    VSYNC_in = 1'b0;
    tick(1);
    VSYNC_in = 1'b1;
    tick(10);
    n_checks++;
    if (lt_active !== 1'b1) $display("FAIL pre_reset_act got %b exp 1", lt_active);
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({lt_active, busy, lt_mode, timeout, lat_result, stb_result} !== 53'd0)
      $display("FAIL async_reset got act=%b busy=%b mode=%b to=%b lat=%0d stb=%0d exp all 0",
               lt_active, busy, lt_mode, timeout, lat_result, stb_result);
    else n_pass++;
    #2 reset_n = 1'b1;
    tick(5);
    n_checks++;
    if ({busy, lt_active, n_done} !== {2'b00, 32'sd3})
      $display("FAIL post_reset got busy=%b act=%b done_count=%0d exp 0 0 3", busy, lt_active, n_done);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_measure();
    test_sensor_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lat_tester_ctrl.md
LAT_TESTER_CTRL -- requirements
Module: lat_tester_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd13500000, measurement abort limit in clk27 cycles (0.5 s).
REQ-002 SHALL have parameter DEBOUNCE_LEN, default 8'd16, consecutive stable cycles required by the sensor filter.
REQ-003 SHALL have port clk27  input  1  pixel/system clock, 27 MHz, single clock domain.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-006 SHALL have port abort  input  1  synchronous cancel of any measurement in progress.
REQ-007 SHALL have port mode_in  input  2  box position code (LT_POS_*) sampled on accepted start.
REQ-008 SHALL have port VSYNC_in  input  1  negative-polarity vsync from the video generator, clk27 domain.
REQ-009 SHALL have port sensor_n  input  1  asynchronous photodiode input, low = light detected.
REQ-010 SHALL have port lt_active  output  1  box-draw enable to the video generator.
REQ-011 SHALL have port lt_mode  output  2  box position to the video generator.
REQ-012 SHALL have ports busy, done, timeout, sensor_err  output  1 each  status; done is a one-cycle pulse.
REQ-013 SHALL have ports lat_result, stb_result  output  24 each  measured cycle counts.

Function
REQ-014 SHALL synchronise sensor_n through two flops, invert it to active-high sensor_on, then pass it through the filter of REQ-032/033.
REQ-015 SHALL detect frame start as VSYNC_in 1 in previous cycle and 0 in current cycle; VSYNC_in is not resynchronised.
REQ-016 SHALL implement states IDLE, WAIT_FRAME, MEASURE, RELEASE, DONE; busy=1 in all but IDLE.
REQ-017 IDLE: start=1 SHALL latch mode_in into lt_mode, clear timeout and sensor_err, go WAIT_FRAME; start in any other state is ignored.
REQ-018 WAIT_FRAME on frame start: if filtered sensor_on=1, SHALL set sensor_err and go DONE; else SHALL set lt_active=1, clear the counter, go MEASURE.
REQ-019 MEASURE: counter SHALL read 0 in the first MEASURE cycle and increment by 1 per cycle.
REQ-020 MEASURE with filtered sensor_on=1: SHALL load lat_result with the counter value of that cycle, clear lt_active and the counter, go RELEASE.
REQ-021 RELEASE: counter increments; filtered sensor_on=0 SHALL load stb_result with the counter value, go DONE.
REQ-022 In MEASURE or RELEASE, counter equal to TIMEOUT_CYCLES-1 without the exit event SHALL set timeout, clear lt_active, go DONE; result registers keep prior values for the stage that timed out.
REQ-023 Sensor and timeout in the same cycle: sensor event SHALL win.
REQ-024 DONE SHALL assert done for exactly one cycle, then go IDLE.
REQ-025 abort=1 in any state SHALL clear lt_active, go IDLE next cycle, no done pulse; abort has priority over start in the same cycle.
REQ-026 Sync and filter delay SHALL NOT be subtracted from results; software compensates.
REQ-027 lat_result, stb_result, timeout, sensor_err SHALL hold until the next accepted start.

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE and lt_active, lt_mode, busy, done, timeout, sensor_err, lat_result, stb_result, counter, synchroniser and filter all to 0.
REQ-029 Reset mid-MEASURE SHALL drop lt_active immediately without waiting for a clock edge.

Configuration
REQ-030 Macro LT_SENSOR_DEBOUNCE_EN SHALL select the sensor filter.
REQ-031 Filtered sensor_on SHALL change only when the synchronised value differs from it for DEBOUNCE_LEN consecutive cycles.
REQ-032 With LT_SENSOR_DEBOUNCE_EN defined, the REQ-031 filter SHALL apply.
REQ-033 Without LT_SENSOR_DEBOUNCE_EN, filtered sensor_on SHALL equal the synchronised value, zero added delay.

Structure
REQ-034 Shared package lat_tester_pkg SHALL hold the state encoding, LT_POS_* codes, LT_WIDTH_DIV/LT_HEIGHT_DIV and default TIMEOUT_CYCLES.
REQ-035 The synchroniser and debounce filter SHALL be sub-module lt_sensor_filter.

Verification
REQ-036 Debounce off, start with mode 2'b01, frame start, sensor_n low 1000 cycles later -> lt_active rises the cycle after the VSYNC falling edge, lat_result = 1002, one done pulse.
REQ-037 Debounce on, DEBOUNCE_LEN=16, same stimulus -> lat_result = 1018; 10-cycle glitch on sensor_n earlier produces no event.
REQ-038 sensor_n held low before frame start -> sensor_err=1, lt_active never asserted, done pulses once.
REQ-039 TIMEOUT_CYCLES=100, no sensor -> timeout=1 at counter 99, lt_active=0, done pulses once.
REQ-040 Sensor released 500 cycles after detection, debounce off -> stb_result = 501.
REQ-041 abort during MEASURE, and reset_n low during MEASURE -> lt_active 0, state IDLE, no done; start during busy ignored.
